// File: rtl/sddr_init_seq_if.sv
// sddr_init_seq_if: register bus between a controller (master) and sddr_init_seq (slave)
// Ports (signals):
//   ctrl_cmd_valid/ctrl_cmd_write/ctrl_cmd_address/ctrl_cmd_data : request, driven by master
//   ctrl_cmd_ack/ctrl_rsp_ready/ctrl_rsp_data                     : response, driven by slave
interface sddr_init_seq_if;
    logic        ctrl_cmd_valid;
    logic        ctrl_cmd_write;
    logic [15:0] ctrl_cmd_address;
    logic [31:0] ctrl_cmd_data;
    logic        ctrl_cmd_ack;
    logic        ctrl_rsp_ready;
    logic [31:0] ctrl_rsp_data;
    modport master (
        output ctrl_cmd_valid, ctrl_cmd_write, ctrl_cmd_address, ctrl_cmd_data,
        input  ctrl_cmd_ack, ctrl_rsp_ready, ctrl_rsp_data
    );
    modport slave (
        input  ctrl_cmd_valid, ctrl_cmd_write, ctrl_cmd_address, ctrl_cmd_data,
        output ctrl_cmd_ack, ctrl_rsp_ready, ctrl_rsp_data
    );
endinterface

// File: rtl/sddr_init_seq.sv
// sddr_init_seq: DDR3 power-up / mode-register / ZQ calibration sequencer with a register bus
// Ports:
//   cpu_clock_i, reset_i    : clock and synchronous active-high reset
//   bus (slave modport)     : register bus (CTRL 0x0, MR0..MR3 0x1..0x4, STATUS 0x10)
//   ddr_reset_n_o, ddr_phy_reset_n_o, ddr3_cke_o, ddr3_odt_o : DDR3 reset/clock-enable/ODT pins
//   ddr3_ras_n_o, ddr3_cas_n_o, ddr3_we_n_o, ddr3_ba_o, ddr3_addr_o : DDR3 command pins
//   init_done_o             : high in DONE and REFRESH
// Optional feature: define SDDR_AUTO_REFRESH_EN to issue periodic REF commands from DONE.
module sddr_init_seq #(
    parameter int BANK_BITS = 3,
    parameter int ADDR_BITS = 14,
    parameter int T_RESET   = 40000,
    parameter int T_CKE     = 100000,
    parameter int T_XPR     = 54,
    parameter int T_MRD     = 4,
    parameter int T_MOD     = 12,
    parameter int T_ZQINIT  = 512,
    parameter int T_REFI    = 1560,
    parameter int T_RFC     = 44
) (
    input  logic                 cpu_clock_i,
    input  logic                 reset_i,
    sddr_init_seq_if.slave       bus,
    output logic                 ddr_reset_n_o,
    output logic                 ddr_phy_reset_n_o,
    output logic                 ddr3_cke_o,
    output logic                 ddr3_odt_o,
    output logic                 ddr3_ras_n_o,
    output logic                 ddr3_cas_n_o,
    output logic                 ddr3_we_n_o,
    output logic [BANK_BITS-1:0] ddr3_ba_o,
    output logic [ADDR_BITS-1:0] ddr3_addr_o,
    output logic                 init_done_o
);
    function automatic int maxi(int a, int b);
        return a > b ? a : b;
    endfunction
    localparam int T_MAX = maxi(maxi(maxi(T_RESET, T_CKE), maxi(T_XPR, T_MRD)),
                                maxi(maxi(T_MOD, T_ZQINIT), maxi(T_REFI, T_RFC)));
    localparam int CW = $clog2(T_MAX) + 1;
    localparam logic [ADDR_BITS-1:0] ZQ_ADDR = ADDR_BITS'(1024);
    typedef enum logic [2:0] {
        IDLE = 3'd0, RST_HOLD = 3'd1, CKE_WAIT = 3'd2, XPR_WAIT = 3'd3,
        MRS = 3'd4, ZQCL = 3'd5, DONE = 3'd6, REFRESH = 3'd7
    } state_t;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [1:0]           mrs_idx;
    logic [ADDR_BITS-1:0] mr [4];
    logic                 wr, rd, start, abort, mr_hit;
    logic [1:0]           mr_sel, mrs_next, mrs_bank;
    logic [31:0]          rd_val;
    logic                 unused_data;
    assign bus.ctrl_cmd_ack = 1'b1;
    assign ddr3_odt_o       = 1'b0;
    assign unused_data      = ^bus.ctrl_cmd_data[31:ADDR_BITS];
    always_comb begin
        wr       = bus.ctrl_cmd_valid & bus.ctrl_cmd_write;
        rd       = bus.ctrl_cmd_valid & ~bus.ctrl_cmd_write;
        start    = wr && bus.ctrl_cmd_address == 16'h0000 && bus.ctrl_cmd_data[0];
        abort    = wr && bus.ctrl_cmd_address == 16'h0000 && bus.ctrl_cmd_data[1];
        mr_hit   = bus.ctrl_cmd_address >= 16'h0001 && bus.ctrl_cmd_address <= 16'h0004;
        mr_sel   = bus.ctrl_cmd_address[1:0] - 2'd1;
        // slot of the next MRS command; issue order is MR2, MR3, MR1, MR0
        mrs_next = state == MRS ? mrs_idx + 2'd1 : 2'd0;
        mrs_bank = mrs_next[1] ? {1'b0, ~mrs_next[0]} : {1'b1, mrs_next[0]};
        rd_val   = bus.ctrl_cmd_address == 16'h0010 ? {23'd0, init_done_o, 4'd0, 1'b0, state} :
                   mr_hit ? 32'(mr[mr_sel]) : 32'd0;
    end
    always_ff @(posedge cpu_clock_i) begin
        if (reset_i) begin
            state             <= IDLE;
            cnt               <= '0;
            mrs_idx           <= 2'd0;
            mr                <= '{default: '0};
            ddr_reset_n_o     <= 1'b0;
            ddr_phy_reset_n_o <= 1'b0;
            ddr3_cke_o        <= 1'b0;
            {ddr3_ras_n_o, ddr3_cas_n_o, ddr3_we_n_o} <= 3'b111;
            ddr3_ba_o         <= '0;
            ddr3_addr_o       <= '0;
            init_done_o       <= 1'b0;
            bus.ctrl_rsp_ready <= 1'b0;
            bus.ctrl_rsp_data  <= '0;
        end else begin
            bus.ctrl_rsp_ready <= rd;
            bus.ctrl_rsp_data  <= rd ? rd_val : 32'd0;
            if (wr && mr_hit)
                mr[mr_sel] <= bus.ctrl_cmd_data[ADDR_BITS-1:0];
            // every cycle is a NOP unless a command is issued below
            {ddr3_ras_n_o, ddr3_cas_n_o, ddr3_we_n_o} <= 3'b111;
            ddr3_ba_o   <= '0;
            ddr3_addr_o <= '0;
            if (abort) begin
                state             <= IDLE;
                cnt               <= '0;
                mrs_idx           <= 2'd0;
                ddr_reset_n_o     <= 1'b0;
                ddr_phy_reset_n_o <= 1'b0;
                ddr3_cke_o        <= 1'b0;
                init_done_o       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state             <= RST_HOLD;
                        ddr_phy_reset_n_o <= 1'b1;
                        cnt               <= CW'(T_RESET - 1);
                    end
                    RST_HOLD: if (cnt == '0) begin
                        state         <= CKE_WAIT;
                        ddr_reset_n_o <= 1'b1;
                        cnt           <= CW'(T_CKE - 1);
                    end else cnt <= cnt - CW'(1);
                    CKE_WAIT: if (cnt == '0) begin
                        state      <= XPR_WAIT;
                        ddr3_cke_o <= 1'b1;
                        cnt        <= CW'(T_XPR - 1);
                    end else cnt <= cnt - CW'(1);
                    XPR_WAIT: if (cnt == '0) begin
                        state   <= MRS;
                        mrs_idx <= 2'd0;
                        {ddr3_ras_n_o, ddr3_cas_n_o, ddr3_we_n_o} <= 3'b000;
                        ddr3_ba_o   <= BANK_BITS'(mrs_bank);
                        ddr3_addr_o <= mr[mrs_bank];
                        cnt         <= CW'(T_MRD - 1);
                    end else cnt <= cnt - CW'(1);
                    MRS: if (cnt == '0) begin
                        if (mrs_idx == 2'd3) begin
                            state <= ZQCL;
                            {ddr3_ras_n_o, ddr3_cas_n_o, ddr3_we_n_o} <= 3'b110;
                            ddr3_addr_o <= ZQ_ADDR;
                            cnt         <= CW'(T_ZQINIT - 1);
                        end else begin
                            mrs_idx <= mrs_next;
                            {ddr3_ras_n_o, ddr3_cas_n_o, ddr3_we_n_o} <= 3'b000;
                            ddr3_ba_o   <= BANK_BITS'(mrs_bank);
                            ddr3_addr_o <= mr[mrs_bank];
                            // MR0 (last slot) needs tMOD before the next command
                            cnt <= mrs_idx == 2'd2 ? CW'(T_MOD - 1) : CW'(T_MRD - 1);
                        end
                    end else cnt <= cnt - CW'(1);
                    ZQCL: if (cnt == '0) begin
                        state       <= DONE;
                        init_done_o <= 1'b1;
`ifdef SDDR_AUTO_REFRESH_EN
                        cnt         <= CW'(T_REFI - 1);
`else
                        cnt         <= '0;
`endif
                    end else cnt <= cnt - CW'(1);
`ifdef SDDR_AUTO_REFRESH_EN
                    DONE: if (cnt == '0) begin
                        state <= REFRESH;
                        {ddr3_ras_n_o, ddr3_cas_n_o, ddr3_we_n_o} <= 3'b001;
                        cnt   <= CW'(T_RFC - 1);
                    end else cnt <= cnt - CW'(1);
                    REFRESH: if (cnt == '0) begin
                        state <= DONE;
                        cnt   <= CW'(T_REFI - 1);
                    end else cnt <= cnt - CW'(1);
`else
                    DONE, REFRESH: ;
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule
